row_scanner: RTL and testbench
==============================

ROW_SCANNER -- requirements
Module: row_scanner

Interface
REQ-001 Parameter NUM_ROWS, default 20, SHALL set the number of playfield rows scanned (1..32).
REQ-002 Parameter BG_COLOR, default 16'h0000, SHALL set the cell value treated as empty.
REQ-003 Parameter RETRY_CYCLES, default 1024, SHALL set the number of cycles WAIT holds before re-pulsing row_ld.
REQ-004 Parameter MAX_RETRY, default 3, SHALL set the number of retries allowed per row before abort.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high. Ports: clk and reset.
REQ-006 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle scan request, e.g. on piece lock
- row_ready  in  1  upstream row-read complete; read_reg valid this cycle
- read_reg  in  10x16  cell words of the requested row, index 0 = leftmost cell
- row_ld  out  1  one-cycle row-read request to the upstream VRAM stage
- row  out  8  row index for row_ld; held stable from REQ through WAIT
- busy  out  1  high from scan start until the cycle done pulses
- done  out  1  one-cycle pulse at scan end
- full_mask  out  NUM_ROWS  bit r set means row r was full in the last scan
- full_count  out  6  popcount of full_mask
- lines_total  out  16  accumulated full rows since reset
- timeout_err  out  1  sticky; set when a row exceeded MAX_RETRY

Function
REQ-007 States SHALL be IDLE, REQ, WAIT, GAP, EVAL, DONE.
REQ-008 IDLE: start=1 SHALL clear the working mask and retry count, set row=NUM_ROWS-1, and go to REQ. Rows scan bottom-up.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 REQ: the block SHALL assert row_ld for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-011 WAIT: row_ready=1 SHALL capture all 10 read_reg words that cycle and go to GAP.
REQ-012 WAIT: if the wait counter reaches RETRY_CYCLES-1 without row_ready, the block SHALL increment the retry count and go to REQ. When the retry count already equals MAX_RETRY, it SHALL instead set timeout_err and go to DONE.
REQ-013 row_ready outside WAIT SHALL be ignored.
REQ-014 row_ld SHALL never assert in the cycle of, or the cycle after, a row_ready high. GAP lasts exactly one cycle to guarantee this.
REQ-015 GAP SHALL go to EVAL.
REQ-016 EVAL: the row SHALL be full when all 10 captured words differ from BG_COLOR; the block SHALL set working mask bit [row] accordingly.
REQ-017 EVAL: if row=0, go to DONE. Otherwise decrement row, reset the retry count, and go to REQ.
REQ-018 DONE: full_mask and full_count SHALL load from the working state. lines_total SHALL add full_count, saturating at 16'hFFFF. done SHALL pulse, busy SHALL drop, and the state SHALL return to IDLE.
REQ-019 On timeout abort, full_mask and full_count SHALL still load with the rows evaluated so far. Unevaluated bits are 0.
REQ-020 full_mask, full_count and lines_total SHALL change only in DONE and be stable otherwise.
REQ-021 Nominal latency per row SHALL be 4 cycles plus upstream read time: REQ, WAIT≥1, GAP, EVAL.

Reset
REQ-022 Reset SHALL force the following, overriding any state including mid-scan:
- state=IDLE
- row_ld=0, row=0
- busy=0, done=0
- full_mask=0, full_count=0, lines_total=0
- timeout_err=0
- internal counters=0
REQ-023 row_ld SHALL be 0 in the first cycle after reset is sampled high. No partial results SHALL survive reset.

Verification
REQ-024 Scenario: start with the model returning row_ready 5 cycles after each row_ld, rows 19 and 18 all 16'h0F00, others mixed with 16'h0000 -> 20 row_ld pulses with row 19 down to 0; full_mask=20'h C0000; full_count=2; lines_total=2; done pulses once.
REQ-025 Scenario: the model ignores the first row_ld of row 19 and answers the second -> row_ld re-pulses 1024 cycles later with row=19; timeout_err stays 0; scan completes normally.
REQ-026 Scenario: the model never answers -> 4 row_ld pulses for row 19; then timeout_err=1, done pulses, full_mask=0, full_count=0.
REQ-027 Scenario: start is held high for 50 cycles, including mid-scan -> exactly one scan and one done; start=1 in the cycle after done begins a new scan.
REQ-028 Scenario: reset is asserted while in WAIT for row 10 -> next cycle busy=0, row_ld=0, outputs zero; a later stray row_ready is ignored.
REQ-029 Scenario: lines_total preloaded near 16'hFFFE by repeated full scans, then a scan with full_count=20 -> lines_total=16'hFFFF.

Source files
------------

// File: rtl/row_scanner.sv
// Playfield row scanner: requests each row bottom-up from the upstream VRAM stage,
// flags rows with no empty cell, and accumulates the full-row count across scans.
module row_scanner #(
    parameter int unsigned NUM_ROWS     = 20,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter int unsigned RETRY_CYCLES = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                row_ready,
    input  logic [9:0][15:0]    read_reg,
    output logic                row_ld,
    output logic [7:0]          row,
    output logic                busy,
    output logic                done,
    output logic [NUM_ROWS-1:0] full_mask,
    output logic [5:0]          full_count,
    output logic [15:0]         lines_total,
    output logic                timeout_err
);

    localparam int unsigned WAIT_W  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned IDX_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        GAP,
        EVAL,
        DONE
    } state_t;

    state_t               state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [9:0][15:0]     cells;
    logic [NUM_ROWS-1:0]  work_mask;
    logic [5:0]           work_count;
    logic                 row_full;
    logic [16:0]          lines_sum;

    always_comb begin
        row_full = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cells[i] == BG_COLOR) row_full = 1'b0;
        end
    end

    assign lines_sum = {1'b0, lines_total} + 17'(work_count);

    // row_ld is raised on every transition into REQ so it is high exactly for the REQ cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row_ld      <= 1'b0;
            row         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            full_mask   <= '0;
            full_count  <= '0;
            lines_total <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            cells       <= '0;
            work_mask   <= '0;
            work_count  <= '0;
        end else begin
            row_ld <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work_mask  <= '0;
                        work_count <= '0;
                        retry_cnt  <= '0;
                        row        <= 8'(NUM_ROWS - 1);
                        busy       <= 1'b1;
                        row_ld     <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (row_ready) begin
                        cells <= read_reg;
                        state <= GAP;
                    end else if (wait_cnt == WAIT_W'(RETRY_CYCLES - 1)) begin
                        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                            timeout_err <= 1'b1;
                            state       <= DONE;
                        end else begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            row_ld    <= 1'b1;
                            state     <= REQ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                GAP: state <= EVAL;
                EVAL: begin
                    work_mask[row[IDX_W-1:0]] <= row_full;
                    work_count                <= work_count + 6'(row_full);
                    if (row == '0) begin
                        state <= DONE;
                    end else begin
                        row       <= row - 8'd1;
                        retry_cnt <= '0;
                        row_ld    <= 1'b1;
                        state     <= REQ;
                    end
                end
                DONE: begin
                    full_mask   <= work_mask;
                    full_count  <= work_count;
                    lines_total <= lines_sum[16] ? '1 : lines_sum[15:0];
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_scanner.sv
// Directed bench for row_scanner: a cycle-stepped upstream model answers row_ld
// requests with per-row cell patterns whose full/empty outcome is fixed by hand.
module tb_row_scanner;

    localparam int NR   = 20;
    localparam int RESP = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             row_ready;
    logic [9:0][15:0] read_reg;
    logic             row_ld;
    logic [7:0]       row;
    logic             busy;
    logic             done;
    logic [NR-1:0]    full_mask;
    logic [5:0]       full_count;
    logic [15:0]      lines_total;
    logic             timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    row_scanner #(
        .NUM_ROWS    (NR),
        .BG_COLOR    (16'h0000),
        .RETRY_CYCLES(1024),
        .MAX_RETRY   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_ready  (row_ready),
        .read_reg   (read_reg),
        .row_ld     (row_ld),
        .row        (row),
        .busy       (busy),
        .done       (done),
        .full_mask  (full_mask),
        .full_count (full_count),
        .lines_total(lines_total),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pattern 0: rows 18/19 full, others hold one empty cell. Pattern 1: all full.
    // Pattern 2: even rows full; odd rows empty at cell 0 (r%4==1) or cell 9.
    function automatic logic [9:0][15:0] row_words(input int pat, input int r);
        logic [9:0][15:0] w;
        for (int i = 0; i < 10; i++) begin
            case (pat)
                0: w[i] = (r >= 18) ? 16'h0F00 : ((i == r % 10) ? 16'h0000 : 16'h1234);
                1: w[i] = 16'hA5A0 + 16'(i);
                default: begin
                    if (r % 2 == 0) w[i] = 16'h0F0F;
                    else w[i] = (i == ((r % 4 == 1) ? 0 : 9)) ? 16'h0000 : 16'h0F0F;
                end
            endcase
        end
        return w;
    endfunction

    function automatic logic [9:0][15:0] junk_words();
        logic [9:0][15:0] w;
        for (int i = 0; i < 10; i++) w[i] = 16'hFFFF;
        return w;
    endfunction

    // Runs one scan from the current negedge. start_len=0 continues a scan already begun.
    // answer_rows: rows answered before going silent; ignore_n: requests ignored first;
    // stop_row: return right after the row_ld for that row (-1 = run to done).
    task automatic run_scan(input int pat, input int start_len, input int answer_rows,
                            input int ignore_n, input int stop_row, input int budget,
                            output int pulses);
        int cnt, answered, ignored, cur_row, last_t, prev_ans;
        logic finished, stable, busy_ok;
        logic [NR-1:0] m0;
        logic [5:0]    c0;
        logic [15:0]   l0;
        pulses = 0; cnt = 0; answered = 0; ignored = 0; cur_row = NR - 1;
        last_t = -1; prev_ans = 0; finished = 1'b0; stable = 1'b1; busy_ok = 1'b1;
        m0 = full_mask; c0 = full_count; l0 = lines_total;
        if (start_len > 0) begin
            start = 1'b1;
            @(negedge clk);
        end
        for (int t = 0; t < budget; t++) begin
            if (row_ld) begin
                chk("row_ld_after_ready", row_ready, 1'b0);
                chk("row_ld_row", row, cur_row);
                if (last_t >= 0) chk("row_ld_spacing", t - last_t, prev_ans ? 8 : 1025);
                last_t = t;
                pulses++;
                if (int'(row) == stop_row) return;
                if (answered < answer_rows && ignored >= ignore_n) begin
                    cnt = RESP + 1;   // row_ready lands RESP cycles after the row_ld cycle
                    prev_ans = 1;
                end else begin
                    ignored++;
                    prev_ans = 0;
                end
            end
            if (done) begin
                finished = 1'b1;
                chk("done_busy_low", busy, 1'b0);
            end else begin
                if (full_mask !== m0 || full_count !== c0 || lines_total !== l0) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            start     = (t + 1 < start_len);
            row_ready = 1'b0;
            read_reg  = junk_words();
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    row_ready = 1'b1;
                    read_reg  = row_words(pat, cur_row);
                    cur_row--;
                    answered++;
                end
            end
            if (finished) break;
            @(negedge clk);
        end
        chk("scan_finished", finished, 1'b1);
        chk("results_stable_mid_scan", stable, 1'b1);
        chk("busy_during_scan", busy_ok, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_row_ld"}, row_ld, 1'b0);
        chk({tag, "_row"}, row, 8'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_full_mask"}, full_mask, '0);
        chk({tag, "_full_count"}, full_count, 6'd0);
        chk({tag, "_lines_total"}, lines_total, 16'd0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    task automatic chk_result(input string tag, input int pulses, input int exp_pulses,
                              input logic [NR-1:0] mask, input int cnt_e,
                              input logic [15:0] lines, input logic terr);
        chk({tag, "_pulses"}, pulses, exp_pulses);
        chk({tag, "_full_mask"}, full_mask, mask);
        chk({tag, "_full_count"}, full_count, 6'(cnt_e));
        chk({tag, "_lines_total"}, lines_total, lines);
        chk({tag, "_timeout_err"}, timeout_err, terr);
    endtask

    initial begin
        int p;
        reset     = 1'b1;
        start     = 1'b0;
        row_ready = 1'b0;
        read_reg  = junk_words();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Stray row_ready while idle.
        @(negedge clk);
        row_ready = 1'b1;
        read_reg  = row_words(1, 0);
        @(negedge clk);
        row_ready = 1'b0;
        chk("idle_ready_busy", busy, 1'b0);
        chk("idle_ready_row_ld", row_ld, 1'b0);
        @(negedge clk);
        chk("idle_ready_row_ld2", row_ld, 1'b0);
        chk("idle_ready_mask", full_mask, '0);

        run_scan(0, 1, 99, 0, -1, 400, p);
        chk_result("scan_basic", p, 20, 20'hC0000, 2, 16'd2, 1'b0);

        run_scan(2, 1, 99, 0, -1, 400, p);
        chk_result("scan_alt", p, 20, 20'h55555, 10, 16'd12, 1'b0);

        run_scan(0, 1, 99, 1, -1, 1600, p);
        chk_result("scan_retry", p, 21, 20'hC0000, 2, 16'd14, 1'b0);

        run_scan(0, 1, 0, 0, -1, 5000, p);
        chk_result("scan_timeout", p, 4, 20'h00000, 0, 16'd14, 1'b1);

        run_scan(0, 1, 2, 0, -1, 5000, p);
        chk_result("scan_partial", p, 6, 20'hC0000, 2, 16'd16, 1'b1);

        run_scan(1, 50, 99, 0, -1, 400, p);
        chk_result("scan_held_start", p, 20, 20'hFFFFF, 20, 16'd36, 1'b1);

        // start in the cycle after done begins a new scan; reset it while waiting on row 10.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1'b1);
        chk("restart_row_ld", row_ld, 1'b1);
        chk("restart_row", row, 8'd19);
        run_scan(1, 0, 99, 0, 10, 400, p);
        chk("pre_reset_pulses", p, 10);
        row_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("mid_scan_reset");
        row_ready = 1'b1;
        read_reg  = row_words(1, 10);
        @(negedge clk);
        row_ready = 1'b0;
        chk("post_reset_ready_busy", busy, 1'b0);
        chk("post_reset_ready_row_ld", row_ld, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_reset_ready_busy2", busy, 1'b0);
        chk("post_reset_ready_mask", full_mask, '0);

        // Saturation: preload the accumulator close to the top.
        force dut.lines_total = 16'hFFE0;
        @(negedge clk);
        release dut.lines_total;
        @(negedge clk);
        run_scan(1, 1, 99, 0, -1, 400, p);
        chk_result("sat_below", p, 20, 20'hFFFFF, 20, 16'hFFF4, 1'b0);
        run_scan(1, 1, 99, 0, -1, 400, p);
        chk_result("sat_clip", p, 20, 20'hFFFFF, 20, 16'hFFFF, 1'b0);
        run_scan(0, 1, 99, 0, -1, 400, p);
        chk_result("sat_hold", p, 20, 20'hC0000, 2, 16'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
